// File: rtl/run_code_sequencer_pkg.sv
// run_code_sequencer_pkg: shared widths, state encoding and J table for the run-code sequencer
package run_code_sequencer_pkg;
  localparam int RUNCOUNT_LENGTH = 16;
  localparam int RUNINDEX_LENGTH = 5;
  localparam int J_LENGTH = 4;
  localparam int CODE_LEN_W = 5;
  typedef enum logic [1:0] {S_IDLE, S_SEGMENT, S_TAIL, S_DONE} state_t;
  // Entry n sits at bits [4n+3:4n]
  localparam logic [32*J_LENGTH-1:0] J_TABLE = {
    4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
    4'd7, 4'd7, 4'd6, 4'd6, 4'd5, 4'd5, 4'd4, 4'd4,
    4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd2, 4'd2,
    4'd1, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0
  };
endpackage

// File: rtl/run_code_sequencer_j_table_lookup.sv
// j_table_lookup: combinational RUNindex -> J and 2^J
module j_table_lookup
  import run_code_sequencer_pkg::*;
(
  input  logic [RUNINDEX_LENGTH-1:0] i_idx,
  output logic [J_LENGTH-1:0]        o_j,
  output logic [2**J_LENGTH-1:0]     o_pow
);
  assign o_j = J_TABLE[{i_idx, 2'b00} +: J_LENGTH];
  assign o_pow = {{(2**J_LENGTH-1){1'b0}}, 1'b1} << o_j;
endmodule

// File: rtl/run_code_sequencer.sv
// run_code_sequencer: codes one run as segment bits and an optional tail codeword over a valid/ready link
// JLS_RUN_STATS_EN adds a saturating code_count output of accepted codewords.
module run_code_sequencer
  import run_code_sequencer_pkg::*;
#(
  parameter int runcount_length = RUNCOUNT_LENGTH,
  parameter int runindex_length = RUNINDEX_LENGTH,
  parameter int J_length = J_LENGTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [runcount_length-1:0] run_length,
  input  logic                       end_of_line,
  input  logic                       line_start,
  input  logic                       code_ready,
  output logic                       code_valid,
  output logic [runcount_length:0]   code_value,
  output logic [CODE_LEN_W-1:0]      code_len,
  output logic [runindex_length-1:0] run_index,
  output logic                       busy,
  output logic                       done
`ifdef JLS_RUN_STATS_EN
  ,
  output logic [15:0]                code_count
`endif
);
  state_t r_state;
  logic [runcount_length-1:0] r_remaining;
  logic r_eol;
  logic [runindex_length-1:0] r_run_index;
  logic [J_length-1:0] w_j;
  logic [2**J_length-1:0] w_pow;
  logic [runcount_length:0] w_pow_ext, w_rem_ext;
  logic w_fits, w_fire;
  j_table_lookup u_j (.i_idx(r_run_index), .o_j(w_j), .o_pow(w_pow));
  assign w_pow_ext = (runcount_length+1)'(w_pow);
  assign w_rem_ext = {1'b0, r_remaining};
  assign w_fits = w_rem_ext >= w_pow_ext;
  // Outputs decode registered state only, so code_valid never sees code_ready
  always_comb begin
    code_valid = r_state == S_TAIL || (r_state == S_SEGMENT && (w_fits || (r_eol && r_remaining != '0)));
    code_value = r_state == S_TAIL ? (w_rem_ext & (w_pow_ext - (runcount_length+1)'(1)))
                                   : (runcount_length+1)'(code_valid);
    code_len = r_state == S_TAIL ? CODE_LEN_W'(w_j) + CODE_LEN_W'(1) : CODE_LEN_W'(code_valid);
  end
  assign w_fire = code_valid && code_ready;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign run_index = r_run_index;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_remaining <= '0;
      r_eol <= 1'b0;
      r_run_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (line_start) r_run_index <= '0;
          if (start) begin
            r_remaining <= run_length;
            r_eol <= end_of_line;
            r_state <= S_SEGMENT;
          end
        end
        S_SEGMENT: begin
          if (w_fits) begin
            if (w_fire) begin
              r_remaining <= r_remaining - w_pow_ext[runcount_length-1:0];
              if (r_run_index != '1) r_run_index <= r_run_index + runindex_length'(1);
            end
          end else if (!r_eol) r_state <= S_TAIL;
          else if (r_remaining == '0 || w_fire) r_state <= S_DONE;
        end
        S_TAIL: begin
          if (w_fire) begin
            if (r_run_index != '0) r_run_index <= r_run_index - runindex_length'(1);
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef JLS_RUN_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE && line_start)) code_count <= '0;
    else if (w_fire && code_count != 16'hFFFF) code_count <= code_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_run_code_sequencer.sv
// tb_run_code_sequencer: random/directed runs checked against a codeword-list model of the run coder
module tb_run_code_sequencer;
  logic clk = 0, reset = 1, start = 0, end_of_line = 0, line_start = 0, code_ready = 0;
  logic [15:0] run_length = '0;
  logic code_valid, busy, done;
  logic [16:0] code_value;
  logic [4:0] code_len, run_index;
`ifdef JLS_RUN_STATS_EN
  logic [15:0] code_count;
`endif
  int errors = 0, checks = 0;
  int m_idx = 0;
  int exp_v[$], exp_l[$];
  int jt[32] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,4,4,5,5,6,6,7,7,8,9,10,11,12,13,14,15};

  run_code_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .run_length(run_length), .end_of_line(end_of_line),
    .line_start(line_start), .code_ready(code_ready), .code_valid(code_valid), .code_value(code_value),
    .code_len(code_len), .run_index(run_index), .busy(busy), .done(done)
`ifdef JLS_RUN_STATS_EN
    , .code_count(code_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected codeword list for one run, straight from the coding rules
  task automatic model(input int len, input bit eol);
    int rem = len;
    exp_v.delete();
    exp_l.delete();
    while (rem >= (1 << jt[m_idx])) begin
      exp_v.push_back(1);
      exp_l.push_back(1);
      rem -= 1 << jt[m_idx];
      if (m_idx < 31) m_idx++;
    end
    if (eol) begin
      if (rem > 0) begin
        exp_v.push_back(1);
        exp_l.push_back(1);
      end
    end else begin
      exp_v.push_back(rem);
      exp_l.push_back(jt[m_idx] + 1);
      if (m_idx > 0) m_idx--;
    end
  endtask

  task automatic pulse_line_start();
    @(negedge clk) line_start = 1;
    @(negedge clk) line_start = 0;
    m_idx = 0;
  endtask

  task automatic run_code(input int len, input bit eol, input int rdy_pct, input bit poke);
    int cyc = 0, dones = 0, bound = 2000;
    bit pv = 0;
    logic [16:0] pval;
    logic [4:0] plen;
    model(len, eol);
    @(negedge clk);
    start = 1;
    run_length = len[15:0];
    end_of_line = eol;
    @(negedge clk);
    start = 0;
    run_length = 16'($urandom);
    end_of_line = 1'($urandom);
    while (cyc < bound) begin
      code_ready = $urandom_range(99) < rdy_pct;
      start = poke && cyc == 1;
      line_start = poke && cyc == 1;
      if (pv) begin
        chk("stall_valid", code_valid, 1);
        chk("stall_value", code_value, pval);
        chk("stall_len", code_len, plen);
      end
      if (done) dones++;
      if (code_valid && code_ready) begin
        if (exp_v.size() == 0) chk("extra_code", 1, 0);
        else begin
          chk("code_value", code_value, exp_v.pop_front());
          chk("code_len", code_len, exp_l.pop_front());
        end
      end
      pv = code_valid && !code_ready;
      pval = code_value;
      plen = code_len;
      if (!busy) break;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    line_start = 0;
    chk("timeout", cyc < bound, 1);
    chk("codes_left", exp_v.size(), 0);
    chk("done_pulses", dones, 1);
    chk("run_index", run_index, m_idx);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", code_valid, 0);
    chk("rst_value", code_value, 0);
    chk("rst_len", code_len, 0);
    chk("rst_index", run_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    run_code(3, 0, 100, 0);
    chk("idx_after_3_int", run_index, 2);
    run_code(2, 1, 100, 0);
    run_code(5, 1, 100, 1);
    chk("idx_after_5_eol", run_index, 6);
    run_code(20, 1, 70, 0);
    run_code(5, 0, 100, 0);
    chk("idx_after_j3_tail", run_index, 11);
    run_code(6, 1, 30, 1);
    run_code(65535, 1, 100, 0);
    chk("idx_saturated", run_index, 31);
    run_code(65535, 0, 80, 0);
    chk("idx_after_max_tail", run_index, 30);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(3) == 0) pulse_line_start();
      run_code($urandom_range(0, 60), 1'($urandom), $urandom_range(20, 100), 1'($urandom));
    end
    pulse_line_start();
    run_code(4, 1, 100, 0);
    code_ready = 0;
    @(negedge clk);
    start = 1;
    run_length = 16'd1;
    end_of_line = 0;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10 && !(code_valid && code_len == 5'd2); i++) @(negedge clk);
    chk("tail_reached", code_valid && code_len == 5'd2, 1);
    chk("tail_value", code_value, 1);
    reset = 1;
    start = 1;
    line_start = 1;
    @(negedge clk);
    chk("abort_valid", code_valid, 0);
    chk("abort_index", run_index, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    reset = 0;
    start = 0;
    line_start = 0;
    code_ready = 1;
    m_idx = 0;
    begin
      int stray = 0;
      repeat (5) begin
        @(negedge clk);
        if (code_valid || done || busy) stray++;
      end
      chk("abort_quiet", stray, 0);
    end
    run_code(3, 0, 60, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
